// File: rtl/aes_key_expand_store.sv
`default_nettype none
// ============================================================================
// Module      : aes_key_expand_store
// Description : Iterative AES-128 key expansion (one round key per clock)
//               into an 11-entry round-key store with an indexed read port.
//               Macro AES_KEY_READ_REG_EN registers the read port.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_key_expand_store (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         start,
  input  logic [127:0] cipher_key,
  input  logic [3:0]   round,
  output logic [127:0] round_key,
  output logic         busy,
  output logic         ready
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] EXPAND = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  localparam logic [3:0] LAST_ROUND = 4'd10;

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [10:0] idx;
    idx = {~x, 3'b000};
    return SBOX[idx +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Rcon for the round key being produced (index = counter).
  function automatic logic [7:0] rcon(input logic [3:0] n);
    logic [7:0] r;
    case (n)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  logic [1:0]   state;
  logic [3:0]   counter;
  logic [127:0] rk [0:10];

  logic         accept;
  logic [127:0] prev_key;
  logic [127:0] next_key;
  logic [31:0]  w0, w1, w2, w3, temp;
  logic [31:0]  n0, n1, n2, n3;
  logic [127:0] read_sel;

  assign accept = start && ((state == IDLE) || (state == DONE));

  always_comb begin
    prev_key = 128'h0;
    for (int i = 0; i < 10; i++) begin
      if (counter == 4'(i + 1)) prev_key = rk[i];
    end
  end

  assign w0   = prev_key[127:96];
  assign w1   = prev_key[95:64];
  assign w2   = prev_key[63:32];
  assign w3   = prev_key[31:0];
  assign temp = sub_word({w3[23:0], w3[31:24]}) ^ {rcon(counter), 24'h0};
  assign n0   = w0 ^ temp;
  assign n1   = w1 ^ n0;
  assign n2   = w2 ^ n1;
  assign n3   = w3 ^ n2;
  assign next_key = {n0, n1, n2, n3};

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= IDLE;
      counter <= 4'd0;
      busy    <= 1'b0;
      ready   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state   <= EXPAND;
            counter <= 4'd1;
            busy    <= 1'b1;
            ready   <= 1'b0;
          end
        end
        EXPAND: begin
          counter <= counter + 4'd1;
          if (counter == LAST_ROUND) begin
            state   <= DONE;
            counter <= 4'd0;
            busy    <= 1'b0;
            ready   <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          counter <= 4'd0;
          busy    <= 1'b0;
          ready   <= 1'b0;
        end
      endcase
    end
  end

  // Entries beyond RK0 are only rewritten by the expansion walk; a restart
  // leaves stale keys in place until they are overwritten.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < 11; i++) rk[i] <= 128'h0;
    end else begin
      if (accept) rk[0] <= cipher_key;
      for (int i = 1; i < 11; i++) begin
        if ((state == EXPAND) && (counter == 4'(i))) rk[i] <= next_key;
      end
    end
  end

  always_comb begin
    read_sel = 128'h0;
    for (int i = 0; i < 11; i++) begin
      if (round == 4'(i)) read_sel = rk[i];
    end
  end

`ifdef AES_KEY_READ_REG_EN
  logic [127:0] read_q;

  always_ff @(posedge Clk) begin
    if (Reset) read_q <= 128'h0;
    else       read_q <= read_sel;
  end

  assign round_key = read_q;
`else
  assign round_key = read_sel;
`endif

endmodule
`default_nettype wire

// File: tb/tb_aes_key_expand_store.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_key_expand_store
// Description : Self-checking bench for aes_key_expand_store (both read-port
//               builds, selected by AES_KEY_READ_REG_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_key_expand_store;

  logic         Clk;
  logic         Reset;
  logic         start;
  logic [127:0] cipher_key;
  logic [3:0]   round;
  logic [127:0] round_key;
  logic         busy;
  logic         ready;

  aes_key_expand_store dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .start      (start),
    .cipher_key (cipher_key),
    .round      (round),
    .round_key  (round_key),
    .busy       (busy),
    .ready      (ready)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_B = 128'h000102030405060708090a0b0c0d0e0f;

  typedef struct {
    logic [3:0]   rnd;
    logic [127:0] exp;
  } vec_t;

  vec_t         vecs_a [0:13];
  logic [127:0] sb_q [$];
  int           checks = 0;
  int           errors = 0;
  logic         mon_en = 1'b0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive a read index, queue its expectation, compare once the read port has produced it.
  task automatic read_key(input logic [3:0] r, input logic [127:0] exp, input string nm);
    logic [127:0] e;
    @(negedge Clk);
    round = r;
    sb_q.push_back(exp);
`ifdef AES_KEY_READ_REG_EN
    @(posedge Clk);
`endif
    #1;
    e = sb_q.pop_front();
    check(nm, round_key, e);
  endtask

  task automatic wait_ready(input string nm);
    int nbusy;
    int n;
    nbusy = 0;
    n = 0;
    while (!ready && n < 30) begin
      if (busy) nbusy++;
      @(negedge Clk);
      n++;
    end
    check({nm, "_ready"}, 128'(ready), 128'd1);
    check({nm, "_busy_cycles"}, 128'(nbusy), 128'd10);
    check({nm, "_busy_low"}, 128'(busy), 128'd0);
  endtask

  task automatic pulse_start(input logic [127:0] k, input string nm);
    @(negedge Clk);
    start = 1'b1;
    cipher_key = k;
    @(negedge Clk);
    start = 1'b0;
    check({nm, "_busy_after_start"}, 128'(busy), 128'd1);
    check({nm, "_ready_after_start"}, 128'(ready), 128'd0);
  endtask

  always @(negedge Clk) begin
    if (mon_en) begin
      checks++;
      if (busy && ready) begin
        errors++;
        $display("FAIL busy_ready_exclusive: busy %0b ready %0b required not both 1", busy, ready);
      end
    end
  end

  initial begin
    vecs_a[0]  = '{4'd0,  KEY_A};
    vecs_a[1]  = '{4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
    vecs_a[2]  = '{4'd2,  128'hf2c295f27a96b9435935807a7359f67f};
    vecs_a[3]  = '{4'd3,  128'h3d80477d4716fe3e1e237e446d7a883b};
    vecs_a[4]  = '{4'd4,  128'hef44a541a8525b7fb671253bdb0bad00};
    vecs_a[5]  = '{4'd5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc};
    vecs_a[6]  = '{4'd6,  128'h6d88a37a110b3efddbf98641ca0093fd};
    vecs_a[7]  = '{4'd7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f};
    vecs_a[8]  = '{4'd8,  128'head27321b58dbad2312bf5607f8d292f};
    vecs_a[9]  = '{4'd9,  128'hac7766f319fadc2128d12941575c006e};
    vecs_a[10] = '{4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vecs_a[11] = '{4'd11, 128'h0};
    vecs_a[12] = '{4'd12, 128'h0};
    vecs_a[13] = '{4'd15, 128'h0};

    Reset = 1'b1;
    start = 1'b0;
    cipher_key = 128'h0;
    round = 4'd0;
    repeat (3) @(negedge Clk);
    check("reset_busy", 128'(busy), 128'd0);
    check("reset_ready", 128'(ready), 128'd0);
    check("reset_round_key", round_key, 128'h0);
    Reset = 1'b0;
    mon_en = 1'b1;
    read_key(4'd5, 128'h0, "idle_rk5_zero");

    // First expansion and full readback.
    pulse_start(KEY_A, "exp_a");
    wait_ready("exp_a");
    for (int i = 0; i < 14; i++)
      read_key(vecs_a[i].rnd, vecs_a[i].exp, $sformatf("key_a_round%0d", vecs_a[i].rnd));

    // Read latency: a change of round shows at once or only after the next edge.
    read_key(4'd0, KEY_A, "lat_pre_round0");
    @(negedge Clk);
    round = 4'd1;
    #1;
`ifdef AES_KEY_READ_REG_EN
    check("lat_before_edge", round_key, KEY_A);
`else
    check("lat_before_edge", round_key, vecs_a[1].exp);
`endif
    @(posedge Clk);
    #1;
    check("lat_after_edge", round_key, vecs_a[1].exp);

    // start held through EXPAND with a key change mid-way is ignored.
    @(negedge Clk);
    start = 1'b1;
    cipher_key = KEY_A;
    @(posedge Clk);
    for (int k = 1; k <= 10; k++) begin
      @(negedge Clk);
      if (k == 3) cipher_key = KEY_B;
      @(posedge Clk);
    end
    @(negedge Clk);
    start = 1'b0;
    check("held_start_ready", 128'(ready), 128'd1);
    check("held_start_busy", 128'(busy), 128'd0);
    read_key(4'd0, KEY_A, "held_start_rk0");
    read_key(4'd10, vecs_a[10].exp, "held_start_rk10");

    // Reset in the 5th EXPAND cycle, with start also high during Reset.
    pulse_start(KEY_A, "abort");
    repeat (4) @(negedge Clk);
    Reset = 1'b1;
    start = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    start = 1'b0;
    check("abort_busy", 128'(busy), 128'd0);
    check("abort_ready", 128'(ready), 128'd0);
    check("abort_round_key", round_key, 128'h0);
    @(negedge Clk);
    check("abort_start_ignored", 128'(busy), 128'd0);
    for (int r = 0; r < 16; r++)
      read_key(4'(r), 128'h0, $sformatf("abort_zero_round%0d", r));

    pulse_start(KEY_B, "exp_b");
    wait_ready("exp_b");
    read_key(4'd0, KEY_B, "key_b_round0");
    read_key(4'd1, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe, "key_b_round1");
    read_key(4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5, "key_b_round10");
    read_key(4'd11, 128'h0, "key_b_round11");

    // Restart from DONE with a different key.
    pulse_start(KEY_A, "restart");
    wait_ready("restart");
    for (int i = 0; i < 14; i++)
      read_key(vecs_a[i].rnd, vecs_a[i].exp, $sformatf("restart_round%0d", vecs_a[i].rnd));

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/aes_key_expand_store.md
AES_KEY_EXPAND_STORE -- requirements
Module: aes_key_expand_store

Interface
REQ-001 SHALL have one clock and a synchronous active-high reset: Clk input, Reset input, both sampled on rising edge of Clk.
REQ-002 Ports, one per line: name  direction  width  meaning.
- Clk  in  1  rising-edge clock
- Reset  in  1  synchronous active-high reset
- start  in  1  request key expansion, level-sampled
- cipher_key  in  128  AES-128 cipher key, byte 0 at [127:120]
- round  in  4  round-key index to read, 0..10
- round_key  out  128  selected round key; drives the key input of the downstream inverse AddRoundKey stage
- busy  out  1  expansion in progress
- ready  out  1  all 11 round keys valid
REQ-003 SHALL have no parameters; widths are fixed.

Function
REQ-004 SHALL implement FIPS-197 AES-128 key expansion iteratively: one full 128-bit round key per cycle, using RotWord, SubWord (4 forward S-box lookups, table or composite-field) and Rcon = 01,02,04,08,10,20,40,80,1B,36.
REQ-005 SHALL store round keys RK0..RK10 in an internal 11x128 register array, with RK0 = cipher_key.
REQ-006 FSM states: IDLE, EXPAND, DONE.
REQ-007 IDLE/DONE with start=1 at edge T: latch cipher_key into RK0, counter<=1, busy<=1, ready<=0, go to EXPAND.
REQ-008 EXPAND: each edge writes RK[counter] derived from RK[counter-1] and Rcon[counter-1], then increments counter; the edge that writes RK10 goes to DONE with busy<=0 and ready<=1. ready is therefore first high in the cycle after edge T+10.
REQ-009 SHALL ignore start while in EXPAND, with no restart and no change to cipher_key capture.
REQ-010 start in DONE restarts per REQ-007; ready drops the cycle after the restart edge, and old keys are invalid from then on.
REQ-011 round_key SHALL equal RK[round] for round 0..10 and 128'h0 for round 11..15, regardless of state. Content is meaningful only while ready=1.
REQ-012 Read latency is set by REQ-017. Reads while busy=1 return partially updated array contents. This is permitted and not an error.
REQ-013 busy and ready SHALL never be high in the same cycle.

Reset
REQ-014 Reset=1 at an edge: state<=IDLE, counter<=0, busy<=0, ready<=0, all RK entries <=0, registered round_key <=0.
REQ-015 Reset SHALL take priority over start. Reset during EXPAND aborts expansion, and no partial keys survive.
REQ-016 start SHALL be ignored in the cycle Reset is high. The first acceptable start is at the edge after Reset deasserts.

Configuration
REQ-017 Macro AES_KEY_READ_REG_EN:
- Defined: round_key is registered. round sampled at edge N appears after edge N, giving 1-cycle read latency, and reset value 0.
- Undefined: round_key is a combinational mux of the RK array and round, with 0-cycle latency.
- All other behaviour SHALL be identical in both builds.

Verification
REQ-018 Reset, then start=1 for one cycle with cipher_key=2b7e151628aed2a6abf7158809cf4f3c -> busy high 10 cycles, then ready=1; round=0 -> 2b7e151628aed2a6abf7158809cf4f3c.
REQ-019 Same key after ready, round=1 -> a0fafe1788542cb123a339392a6c7605; round=10 -> d014f9a8c9ee2589e13f0cc8b6630ca6. Check the 1-cycle delay with the macro and 0 delay without it.
REQ-020 round=11 and round=15 after ready -> round_key=128'h0.
REQ-021 start held high continuously through EXPAND with cipher_key changed to 000102030405060708090a0b0c0d0e0f at cycle 3 -> ignored; RK10 still d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-022 Reset pulsed at the 5th EXPAND cycle -> next cycle busy=0, ready=0, round_key=0 for all round. A new start with 000102030405060708090a0b0c0d0e0f -> RK10=13111d7fe3944a17f307a78b4d2b30c5.
REQ-023 start in DONE with a new key -> ready=0 the next cycle, busy for 10 cycles, then new RK values read back correctly.
